servo_pulse_meter: RTL
======================

// Module: servo_pulse_meter
// PURPOSE
//   Receive side of the hobby-servo PWM interface: measures the high time of an
//   incoming servo/RC control pulse in microseconds and presents it as a 16-bit
//   value with a one-cycle valid strobe. Sits between an RC receiver pin and
//   logic that consumes pulse_len values in the same units the servo driver takes.
// PARAMETERS
//   CLK_MHZ     100    CLK frequency in MHz; prescaler divides CLK to a 1 us tick
//   MIN_US      500    shortest accepted pulse, us (inclusive)
//   MAX_US      2500   longest accepted pulse, us (inclusive)
//   TIMEOUT_US  25000  no rising edge for this many us -> signal lost
// PORTS
//   CLK          in   1   system clock
//   RST          in   1   synchronous, active-high reset
//   PULSE_IN     in   1   asynchronous servo pulse input from pin
//   pulse_len    out  16  last accepted pulse width, us
//   valid        out  1   one-CLK strobe: pulse_len just updated
//   range_err    out  1   one-CLK strobe: completed pulse outside MIN_US..MAX_US
//   signal_lost  out  1   level: no rising edge for TIMEOUT_US
// BEHAVIOUR
// - Reset values: pulse_len=0, valid=0, range_err=0, signal_lost=1. FSM enters
//   ARM; prescaler and counters cleared.
// - Input path: 2-flop synchroniser, then a 3rd flop for edge detect.
//   All decisions use the synchronised signal.
// - Prescaler: counts 0..CLK_MHZ-1, emits us_tick on wrap. It restarts at 0 on
//   every detected rising edge.
// - FSM:
//   ARM    wait for sync input low (discards a pulse already high at reset
//          release) -> IDLE.
//   IDLE   on rising edge: width_cnt=0 -> HIGH. Every us_tick increments gap_cnt.
//          When gap_cnt reaches TIMEOUT_US, assert signal_lost.
//   HIGH   width_cnt += 1 per us_tick; saturates at 16'hFFFF, no wrap.
//          On falling edge -> IDLE. If MIN_US<=width_cnt<=MAX_US, load
//          pulse_len=width_cnt and pulse valid; otherwise pulse range_err and
//          keep pulse_len.
// - gap_cnt: clears on each rising edge; saturates at TIMEOUT_US.
// - signal_lost:
//   - Clears only on the cycle valid is pulsed.
//   - A stuck-high input also asserts it once width_cnt reaches TIMEOUT_US.
// - Width is floor(high_cycles/CLK_MHZ): full us ticks only.
// - Latency: valid/range_err assert 3 CLKs after the pin falling edge
//   (2 sync + 1 edge register). The strobe is registered.
// - valid and range_err are never asserted together. Each is exactly one cycle.
// - Simultaneous rising edge and timeout in IDLE: the edge wins.
//   gap_cnt clears and signal_lost stays set until the pulse is accepted.
// - RST mid-pulse: measurement discarded. Return to ARM with reset values.
//   No strobe is issued for the interrupted pulse.
// CONFIGURATION
//   PULSE_AVG_EN defined:
//   - pulse_len = average of the last 4 accepted widths:
//     17-bit sum of a 4-entry history, >>2, truncated.
//   - The history is cleared by RST and whenever signal_lost asserts.
//   - Until 4 samples are held, pulse_len is the raw width; valid timing is
//     unchanged.
//   PULSE_AVG_EN undefined:
//   - pulse_len = raw accepted width; no history registers.
// TESTING
//   1 CLK_MHZ=100; 1500 us high pulse -> valid once, pulse_len=1500,
//     3 CLKs after fall.
//   2 Pulses of 499 us and 2501 us -> range_err strobe each, no valid,
//     pulse_len unchanged.
//   3 Pulse of 500 us, then 2500 us -> two valids, pulse_len=500 then 2500.
//   4 20 ms frames, then input held low 25 ms -> signal_lost=1 at 25000 us
//     after last rise; next 1500 us pulse -> valid, signal_lost=0.
//   5 Input high at RST release for 800 us, then low; next 1200 us pulse ->
//     first valid pulse_len=1200; the 800 us fragment is ignored.
//   6 PULSE_AVG_EN: accepted pulses 1000, 1000, 2000, 2000 us ->
//     pulse_len 1000, 1000, 2000, then 1500.

Source files
------------

// File: rtl/servo_pulse_meter_if.sv
// Servo pulse meter bus: the raw pin input and the measurement outputs.
// The meter itself connects through the slave modport.
interface servo_pulse_meter_if;
    logic        PULSE_IN;
    logic [15:0] pulse_len;
    logic        valid;
    logic        range_err;
    logic        signal_lost;

    modport master (
        output PULSE_IN,
        input  pulse_len,
        input  valid,
        input  range_err,
        input  signal_lost
    );

    modport slave (
        input  PULSE_IN,
        output pulse_len,
        output valid,
        output range_err,
        output signal_lost
    );
endinterface

// File: rtl/servo_pulse_meter.sv
// Measures the high time of an RC servo pulse in whole microseconds.
// Optional PULSE_AVG_EN: report the mean of the last four accepted widths.
module servo_pulse_meter #(
    parameter int CLK_MHZ    = 100,
    parameter int MIN_US     = 500,
    parameter int MAX_US     = 2500,
    parameter int TIMEOUT_US = 25000
) (
    input  logic                 CLK,
    input  logic                 RST,
    servo_pulse_meter_if.slave   bus
);

    localparam int PRESC_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t               state_r;
    logic                 sync_meta_r;
    logic                 sync_r;
    logic                 edge_r;
    logic [PRESC_W-1:0]   presc_r;
    logic [15:0]          width_r;
    logic [15:0]          gap_r;
    logic [15:0]          pulse_len_r;
    logic                 valid_r;
    logic                 range_err_r;
    logic                 signal_lost_r;

    logic                 rise_s;
    logic                 fall_s;
    logic [PRESC_W-1:0]   presc_eff_s;
    logic [PRESC_W-1:0]   presc_nxt_s;
    logic                 tick_s;
    logic                 in_range_s;
    logic [15:0]          width_inc_s;
    logic [15:0]          gap_inc_s;
    logic                 lost_set_s;

`ifdef PULSE_AVG_EN
    logic [3:0][15:0]     hist_r;
    logic [2:0]           hist_cnt_r;
    logic [15:0]          avg_s;

    // Mean of the new width and the three most recent history entries.
    function automatic logic [15:0] avg4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
        logic [16:0] sum;
        sum  = 17'(a) + 17'(b) + 17'(c) + 17'(d);
        avg4 = 16'(sum >> 2);
    endfunction
`endif

    // Edge detection, prescaler, saturating increments and timeout detection.
    always_comb begin
        rise_s      = sync_r & ~edge_r;
        fall_s      = ~sync_r & edge_r;
        // The rising-edge cycle counts as prescaler phase 0 of the pulse.
        presc_eff_s = rise_s ? '0 : presc_r;
        tick_s      = (presc_eff_s == PRESC_W'(CLK_MHZ - 1));
        presc_nxt_s = tick_s ? '0 : (presc_eff_s + PRESC_W'(1));
        in_range_s  = (width_r >= 16'(MIN_US)) && (width_r <= 16'(MAX_US));
        width_inc_s = (width_r == 16'hFFFF) ? width_r : (width_r + 16'd1);
        gap_inc_s   = (gap_r >= 16'(TIMEOUT_US)) ? 16'(TIMEOUT_US) : (gap_r + 16'd1);
        case (state_r)
            IDLE:    lost_set_s = !signal_lost_r && !rise_s && tick_s &&
                                  (gap_inc_s >= 16'(TIMEOUT_US));
            HIGH:    lost_set_s = !signal_lost_r && !fall_s && tick_s &&
                                  ((gap_inc_s >= 16'(TIMEOUT_US)) ||
                                   (width_inc_s >= 16'(TIMEOUT_US)));
            default: lost_set_s = 1'b0;
        endcase
    end

`ifdef PULSE_AVG_EN
    // Candidate average including the width being accepted this cycle.
    always_comb begin
        avg_s = avg4(width_r, hist_r[0], hist_r[1], hist_r[2]);
    end
`endif

    // Synchroniser, measurement FSM and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // Sync chain resets high so a pin already high is never seen as a rise.
            sync_meta_r   <= 1'b1;
            sync_r        <= 1'b1;
            edge_r        <= 1'b1;
            state_r       <= ARM;
            presc_r       <= '0;
            width_r       <= 16'd0;
            gap_r         <= 16'd0;
            pulse_len_r   <= 16'd0;
            valid_r       <= 1'b0;
            range_err_r   <= 1'b0;
            signal_lost_r <= 1'b1;
`ifdef PULSE_AVG_EN
            hist_r        <= '0;
            hist_cnt_r    <= 3'd0;
`endif
        end else begin
            sync_meta_r <= bus.PULSE_IN;
            sync_r      <= sync_meta_r;
            edge_r      <= sync_r;
            presc_r     <= presc_nxt_s;
            valid_r     <= 1'b0;
            range_err_r <= 1'b0;
            if (lost_set_s) begin
                signal_lost_r <= 1'b1;
            end
            case (state_r)
                ARM: begin
                    if (!sync_r) begin
                        state_r <= IDLE;
                    end
                end
                IDLE: begin
                    if (rise_s) begin
                        state_r <= HIGH;
                        width_r <= 16'd0;
                        gap_r   <= 16'd0;
                    end else if (tick_s) begin
                        gap_r <= gap_inc_s;
                    end
                end
                HIGH: begin
                    if (tick_s) begin
                        gap_r <= gap_inc_s;
                    end
                    if (fall_s) begin
                        state_r <= IDLE;
                        if (in_range_s) begin
                            valid_r       <= 1'b1;
                            signal_lost_r <= 1'b0;
`ifdef PULSE_AVG_EN
                            hist_r      <= {hist_r[2:0], width_r};
                            hist_cnt_r  <= (hist_cnt_r == 3'd4) ? 3'd4 : (hist_cnt_r + 3'd1);
                            pulse_len_r <= (hist_cnt_r >= 3'd3) ? avg_s : width_r;
`else
                            pulse_len_r <= width_r;
`endif
                        end else begin
                            range_err_r <= 1'b1;
                        end
                    end else if (tick_s) begin
                        width_r <= width_inc_s;
                    end
                end
                default: state_r <= ARM;
            endcase
`ifdef PULSE_AVG_EN
            // A lost signal invalidates the averaging history.
            if (lost_set_s) begin
                hist_r     <= '0;
                hist_cnt_r <= 3'd0;
            end
`endif
        end
    end

    assign bus.pulse_len   = pulse_len_r;
    assign bus.valid       = valid_r;
    assign bus.range_err   = range_err_r;
    assign bus.signal_lost = signal_lost_r;

endmodule
